alu_issue_ctrl: RTL

Issue controller that sits between the RX stage and the decode/ALU pair. It buffers received instructions in a small queue and drops NOOP or illegal opcodes. It issues one instruction at a time to decode with a valid/ready handshake, waits for the ALU result with a timeout, and hands the result to the TX stage. Only one instruction is in flight in the ALU at any time; the queue lets RX keep accepting bytes while the ALU is busy.

---
 rtl/alu_pkg.sv | 44 ++++
 rtl/instr_fifo.sv | 70 +++++++
 rtl/alu_issue_ctrl.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types for the ALU issue controller.
//   - Opcode constants NOOP..LERPY (0x00..0x0F); anything above LERPY is illegal.
//   - instr_t: packed 40-bit instruction {op, a1, a2, b1, b2}.
//   - issue_state_t: issue FSM states.
//   - is_legal_op(): true for opcodes 0x01..0x0F.
package alu_pkg;

  localparam logic [7:0] NOOP   = 8'h00;
  localparam logic [7:0] DOT2   = 8'h01;
  localparam logic [7:0] VADD2  = 8'h02;
  localparam logic [7:0] VSUB2  = 8'h03;
  localparam logic [7:0] VMUL2  = 8'h04;
  localparam logic [7:0] CROSS2 = 8'h05;
  localparam logic [7:0] MAG2   = 8'h06;
  localparam logic [7:0] SCALE2 = 8'h07;
  localparam logic [7:0] NEG2   = 8'h08;
  localparam logic [7:0] ABS2   = 8'h09;
  localparam logic [7:0] MIN2   = 8'h0A;
  localparam logic [7:0] MAX2   = 8'h0B;
  localparam logic [7:0] AVG2   = 8'h0C;
  localparam logic [7:0] SWAP2  = 8'h0D;
  localparam logic [7:0] LERPX  = 8'h0E;
  localparam logic [7:0] LERPY  = 8'h0F;

  typedef struct packed {
    logic [7:0] op;
    logic [7:0] a1;
    logic [7:0] a2;
    logic [7:0] b1;
    logic [7:0] b2;
  } instr_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    SEND
  } issue_state_t;

  function automatic logic is_legal_op(input logic [7:0] op);
    return (op != NOOP) && (op <= LERPY);
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Small synchronous FIFO holding instructions between RX and the issue FSM.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_i        : write din_i (ignored while full)
//   pop_i         : drop the head entry (ignored while empty)
//   din_i         : entry to write
//   dout_o        : current head entry, combinational from storage
//   full_o        : DEPTH entries held
//   empty_o       : no entries held
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module instr_fifo
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter type         T     = instr_t
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic push_i,
  input  logic pop_i,
  input  T     din_i,
  output T     dout_o,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  T                mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]   count_q, count_d;
  logic            push_en, pop_en;

  assign full_o  = (count_q == (PtrW + 1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_en = push_i && !full_o;
  assign pop_en  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_en) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop_en)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    if (push_en && !pop_en) begin
      count_d = count_q + (PtrW + 1)'(1);
    end else if (pop_en && !push_en) begin
      count_d = count_q - (PtrW + 1)'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: nothing is read until count_q says it was written.
  always_ff @(posedge clk_i) begin
    if (push_en) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller between RX and the decode/ALU pair.
//   clk, rst_n               : clock, asynchronous active-low reset
//   rx_valid_in/rx_ready_out : instruction handshake from RX (ready = queue not full)
//   op_in,a1_in..b2_in       : instruction fields from RX
//   cmd_valid_out/cmd_ready_in, cmd_op..cmd_b2 : registered instruction to decode
//   res_valid_in, res_data_in: one-cycle ALU result strobe
//   tx_valid_out/tx_ready_in, tx_data_out, tx_err_out : registered result to TX
//   busy_out                 : queue non-empty or FSM not idle
// Illegal opcodes are dropped at the queue head. One instruction is in flight at a time;
// a missing result is turned into an error response after TIMEOUT cycles.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned RES_W   = 18,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx_valid_in,
  output logic             rx_ready_out,
  input  logic [7:0]       op_in,
  input  logic [7:0]       a1_in,
  input  logic [7:0]       a2_in,
  input  logic [7:0]       b1_in,
  input  logic [7:0]       b2_in,
  output logic             cmd_valid_out,
  input  logic             cmd_ready_in,
  output logic [7:0]       cmd_op,
  output logic [7:0]       cmd_a1,
  output logic [7:0]       cmd_a2,
  output logic [7:0]       cmd_b1,
  output logic [7:0]       cmd_b2,
  input  logic             res_valid_in,
  input  logic [RES_W-1:0] res_data_in,
  output logic             tx_valid_out,
  input  logic             tx_ready_in,
  output logic [RES_W-1:0] tx_data_out,
  output logic             tx_err_out,
  output logic             busy_out
);

  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  issue_state_t     state_q, state_d;
  instr_t           cmd_q, cmd_d;
  logic [7:0]       timer_q, timer_d;
  logic [RES_W-1:0] tx_data_q, tx_data_d;
  logic             tx_err_q, tx_err_d;

  instr_t rx_instr, head;
  logic   push, pop, fifo_full, fifo_empty;

  assign rx_instr = '{op: op_in, a1: a1_in, a2: a2_in, b1: b1_in, b2: b2_in};
  assign push     = rx_valid_in && rx_ready_out;

  instr_fifo #(
    .DEPTH(DEPTH),
    .T    (instr_t)
  ) u_instr_fifo (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .push_i (push),
    .pop_i  (pop),
    .din_i  (rx_instr),
    .dout_o (head),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    timer_d   = timer_q;
    tx_data_d = tx_data_q;
    tx_err_d  = tx_err_q;
    pop       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          // Illegal heads are popped without leaving IDLE.
          pop = 1'b1;
          if (is_legal_op(head.op)) begin
            cmd_d   = head;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (cmd_ready_in) begin
          timer_d = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        timer_d = timer_q + 8'd1;
        // A result arriving on the timeout cycle takes priority over the error.
        if (res_valid_in) begin
          tx_data_d = res_data_in;
          tx_err_d  = 1'b0;
          state_d   = SEND;
        end else if (timer_q == TimeoutLast) begin
          tx_data_d = '0;
          tx_err_d  = 1'b1;
          state_d   = SEND;
        end
      end
      SEND: begin
        if (tx_ready_in) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cmd_q     <= '0;
      timer_q   <= '0;
      tx_data_q <= '0;
      tx_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      timer_q   <= timer_d;
      tx_data_q <= tx_data_d;
      tx_err_q  <= tx_err_d;
    end
  end

  assign rx_ready_out  = !fifo_full;
  assign cmd_valid_out = (state_q == ISSUE);
  assign cmd_op        = cmd_q.op;
  assign cmd_a1        = cmd_q.a1;
  assign cmd_a2        = cmd_q.a2;
  assign cmd_b1        = cmd_q.b1;
  assign cmd_b2        = cmd_q.b2;
  assign tx_valid_out  = (state_q == SEND);
  assign tx_data_out   = tx_data_q;
  assign tx_err_out    = tx_err_q;
  assign busy_out      = (state_q != IDLE) || !fifo_empty;

endmodule
